serial_word_loader: RTL and testbench
=====================================

# serial_word_loader

- Serial-to-parallel front end that feeds the team's N-bit load register.
- Collects N serial bits under a start/valid protocol and presents the assembled word on `word`.
- Pulses `load` for exactly one cycle when the word is complete.
- `word` and `load` connect directly to the register's `D` and `load` inputs, so a completed word is captured by the register on the next clock edge.

## Interface

Parameters:
- `N`, default 8: word width in bits; legal values are N >= 2.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `word[N-1]`; 0 means it lands in `word[0]`.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: single-cycle pulse that begins a new frame.
- `sin_valid`, input, 1: `sin` carries a data bit this cycle.
- `sin`, input, 1: serial data bit.
- `word`, output, N: last completed word; holds its value between completions.
- `load`, output, 1: one-cycle strobe, high in the cycle `word` first shows a new value.
- `busy`, output, 1: high while a frame is being collected (state SHIFT).
- `frame_err`, output, 1: one-cycle pulse when a frame is abandoned by a new `start`.

## Operation

- Internal state: shift register `sr[N-1:0]`, bit counter `cnt` of width `$clog2(N+1)`, and a state machine.
- State IDLE:
  - `start`=1 moves to SHIFT and clears `sr` and `cnt`.
  - `sin_valid` and `sin` are ignored, including in the cycle where `start` is high.
- State SHIFT, priority order:
  - `start`=1: clear `sr` and `cnt`, stay in SHIFT, pulse `frame_err` next cycle. The `sin` bit in that cycle is discarded.
  - Else if `sin_valid`=1, shift in `sin`:
    - MSB_FIRST=1: `sr <= {sr[N-2:0], sin}`.
    - MSB_FIRST=0: `sr <= {sin, sr[N-1:1]}`.
    - Then `cnt <= cnt+1`.
  - When the shifted bit is the Nth (`cnt`==N-1 with `sin_valid`=1):
    - `word` is set to the completed shift value on the same edge.
    - `load` is set to 1 and the state moves to DONE.
  - `sin_valid`=0: hold `sr` and `cnt`. Gaps of any length are legal; there is no timeout.
- State DONE (lasts one cycle):
  - `load` is 1 in this cycle.
  - Next state is SHIFT if `start`=1 (fresh frame, `sr` and `cnt` cleared), else IDLE.
  - `sin` bits in this cycle are ignored.
- `word` changes only on frame completion, never on abort or restart.
- `busy` = (state==SHIFT), driven from a register.
- `frame_err` = 1 for one cycle after each restart in SHIFT.
- Reset mid-frame: all state is cleared immediately (asynchronously), the partial frame is lost, and no `load` or `frame_err` is produced.

## Timing

- Reset values: `word`=0, `load`=0, `busy`=0, `frame_err`=0, state=IDLE, `sr`=0, `cnt`=0.
- All outputs are registered; there is no combinational path from any input to any output.
- Back-to-back latency: `start` in cycle 0 and `sin_valid` in cycles 1..N give `load`=1 and the new `word` in cycle N+1.
- The downstream register holds the new word from cycle N+2.
- With gaps, `load` follows the edge that samples the Nth valid bit by one cycle.
- `busy` rises in cycle 1 (after the `start` edge) and falls in the cycle `load` rises.
- Minimum frame spacing is N+1 cycles: `start` may be asserted in the DONE cycle.
- `load` is never high for two consecutive cycles.

## Test plan

- Use N=4 and MSB_FIRST=1 unless stated otherwise.
- Basic frame: `start` then bits 1,0,1,1 on consecutive cycles.
  - `word`=4'b1011.
  - `load`=1 for exactly one cycle, at cycle 5.
  - `busy` high in cycles 1–4.
  - A downstream 4-bit load register shows Q=4'b1011 at cycle 6.
- Bit order: MSB_FIRST=0 with the same bits 1,0,1,1.
  - `word`=4'b1101.
- Gaps: bits 0,1,1,0 with `sin_valid` low for 3 cycles between each bit.
  - `word`=4'b0110.
  - `load` one cycle after the 4th valid bit.
  - `word` keeps its prior value until then.
- Restart: `start`, bits 1,1; then `start` with `sin_valid`=1; then bits 0,0,1,0.
  - `frame_err` pulses once.
  - `word`=4'b0010.
  - Exactly one `load`.
- Reset mid-frame: `rst` pulsed asynchronously (between clock edges) after 2 of 4 bits.
  - All outputs go to 0 immediately.
  - No `load` is produced.
  - A following full frame 1,1,1,1 gives `word`=4'b1111.
- Back-to-back: `start` asserted in the DONE cycle, then frames 4'b1010 and 4'b0101.
  - Two `load` pulses, 5 cycles apart.
  - `word` values in order: 4'b1010, then 4'b0101.

Source files
------------

// File: rtl/serial_word_loader.sv
// Serial-to-parallel front end: collects N bits under a start/valid protocol and
// presents the finished word with a one-cycle load strobe for a downstream register.
module serial_word_loader #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sin_valid,
  input  logic         sin,
  output logic [N-1:0] word,
  output logic         load,
  output logic         busy,
  output logic         frame_err
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     word_q, word_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic [N-1:0]     sr_shifted;

  // Bit order is a static choice; both slices are legal because N >= 2.
  assign sr_shifted = (MSB_FIRST != 0) ? {sr_q[N-2:0], sin} : {sin, sr_q[N-1:1]};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    load_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          // Abandon the partial frame; the bit presented alongside start is dropped.
          sr_d   = '0;
          cnt_d  = '0;
          ferr_d = 1'b1;
        end else if (sin_valid) begin
          sr_d  = sr_shifted;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            word_d  = sr_shifted;
            load_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d = SHIFT;
          sr_d    = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
    end
  end

  assign word      = word_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader (N=4) with MSB-first and LSB-first instances
// sharing one stimulus stream, plus a model of the downstream load register.
module tb_serial_word_loader;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sin_valid;
  logic         sin;
  logic [N-1:0] word_m, word_l;
  logic         load_m, load_l;
  logic         busy_m, busy_l;
  logic         ferr_m, ferr_l;
  logic [N-1:0] q_reg;

  int tests;
  int fails;

  serial_word_loader #(.N(N), .MSB_FIRST(1)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sin_valid (sin_valid),
    .sin       (sin),
    .word      (word_m),
    .load      (load_m),
    .busy      (busy_m),
    .frame_err (ferr_m)
  );

  serial_word_loader #(.N(N), .MSB_FIRST(0)) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sin_valid (sin_valid),
    .sin       (sin),
    .word      (word_l),
    .load      (load_l),
    .busy      (busy_l),
    .frame_err (ferr_l)
  );

  // Downstream N-bit load register fed directly by the MSB-first instance.
  always @(posedge clk or posedge rst) begin
    if (rst) q_reg <= '0;
    else if (load_m) q_reg <= word_m;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         st;
    logic         va;
    logic         s;
    logic [N-1:0] w;
    logic [N-1:0] wl;
    logic [N-1:0] q;
    logic         ld;
    logic         bz;
    logic         fe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic va, input logic s,
                              input logic [N-1:0] w, input logic [N-1:0] wl,
                              input logic [N-1:0] q, input logic ld,
                              input logic bz, input logic fe);
    vec_t v;
    v.st = st; v.va = va; v.s = s;
    v.w = w; v.wl = wl; v.q = q;
    v.ld = ld; v.bz = bz; v.fe = fe;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic va, input logic s);
    start     = st;
    sin_valid = va;
    sin       = s;
  endtask

  initial begin
    bit saw_load;
    tests = 0;
    fails = 0;
    drive(0, 0, 0);
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_word", 8'(word_m), 8'h0);
    check("rst_load", 8'(load_m), 8'h0);
    check("rst_busy", 8'(busy_m), 8'h0);
    check("rst_ferr", 8'(ferr_m), 8'h0);
    #10 rst = 1'b0;

    // Basic frame 1,0,1,1
    vecs.push_back(mk(1,0,0, 4'h0,4'h0,4'h0, 0,0,0));
    vecs.push_back(mk(0,1,1, 4'h0,4'h0,4'h0, 0,1,0));
    vecs.push_back(mk(0,1,0, 4'h0,4'h0,4'h0, 0,1,0));
    vecs.push_back(mk(0,1,1, 4'h0,4'h0,4'h0, 0,1,0));
    vecs.push_back(mk(0,1,1, 4'h0,4'h0,4'h0, 0,1,0));
    vecs.push_back(mk(0,0,0, 4'hB,4'hD,4'h0, 1,0,0));
    vecs.push_back(mk(0,0,0, 4'hB,4'hD,4'hB, 0,0,0));
    // Gaps: bits 0,1,1,0 with three idle cycles between (sin toggled while invalid)
    vecs.push_back(mk(1,0,1, 4'hB,4'hD,4'hB, 0,0,0));
    vecs.push_back(mk(0,1,0, 4'hB,4'hD,4'hB, 0,1,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,1, 4'hB,4'hD,4'hB, 0,1,0));
    vecs.push_back(mk(0,1,1, 4'hB,4'hD,4'hB, 0,1,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0, 4'hB,4'hD,4'hB, 0,1,0));
    vecs.push_back(mk(0,1,1, 4'hB,4'hD,4'hB, 0,1,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,1, 4'hB,4'hD,4'hB, 0,1,0));
    vecs.push_back(mk(0,1,0, 4'hB,4'hD,4'hB, 0,1,0));
    vecs.push_back(mk(0,0,0, 4'h6,4'h6,4'hB, 1,0,0));
    vecs.push_back(mk(0,0,0, 4'h6,4'h6,4'h6, 0,0,0));
    // Restart: start,1,1, start+valid, 0,0,1,0
    vecs.push_back(mk(1,1,1, 4'h6,4'h6,4'h6, 0,0,0));
    vecs.push_back(mk(0,1,1, 4'h6,4'h6,4'h6, 0,1,0));
    vecs.push_back(mk(0,1,1, 4'h6,4'h6,4'h6, 0,1,0));
    vecs.push_back(mk(1,1,1, 4'h6,4'h6,4'h6, 0,1,0));
    vecs.push_back(mk(0,1,0, 4'h6,4'h6,4'h6, 0,1,1));
    vecs.push_back(mk(0,1,0, 4'h6,4'h6,4'h6, 0,1,0));
    vecs.push_back(mk(0,1,1, 4'h6,4'h6,4'h6, 0,1,0));
    vecs.push_back(mk(0,1,0, 4'h6,4'h6,4'h6, 0,1,0));
    vecs.push_back(mk(0,0,0, 4'h2,4'h4,4'h6, 1,0,0));
    vecs.push_back(mk(0,0,0, 4'h2,4'h4,4'h2, 0,0,0));
    // Back-to-back: 1010, then start in DONE, 0101
    vecs.push_back(mk(1,0,0, 4'h2,4'h4,4'h2, 0,0,0));
    vecs.push_back(mk(0,1,1, 4'h2,4'h4,4'h2, 0,1,0));
    vecs.push_back(mk(0,1,0, 4'h2,4'h4,4'h2, 0,1,0));
    vecs.push_back(mk(0,1,1, 4'h2,4'h4,4'h2, 0,1,0));
    vecs.push_back(mk(0,1,0, 4'h2,4'h4,4'h2, 0,1,0));
    vecs.push_back(mk(1,1,1, 4'hA,4'h5,4'h2, 1,0,0));
    vecs.push_back(mk(0,1,0, 4'hA,4'h5,4'hA, 0,1,0));
    vecs.push_back(mk(0,1,1, 4'hA,4'h5,4'hA, 0,1,0));
    vecs.push_back(mk(0,1,0, 4'hA,4'h5,4'hA, 0,1,0));
    vecs.push_back(mk(0,1,1, 4'hA,4'h5,4'hA, 0,1,0));
    vecs.push_back(mk(0,0,0, 4'h5,4'hA,4'hA, 1,0,0));
    vecs.push_back(mk(0,0,0, 4'h5,4'hA,4'h5, 0,0,0));

    // Each row: outputs expected in this cycle, inputs applied in this cycle.
    foreach (vecs[i]) begin
      @(negedge clk);
      check($sformatf("v%0d_word", i),    8'(word_m), 8'(vecs[i].w));
      check($sformatf("v%0d_word_lsb", i), 8'(word_l), 8'(vecs[i].wl));
      check($sformatf("v%0d_q", i),       8'(q_reg),  8'(vecs[i].q));
      check($sformatf("v%0d_load", i),    8'(load_m), 8'(vecs[i].ld));
      check($sformatf("v%0d_load_lsb", i), 8'(load_l), 8'(vecs[i].ld));
      check($sformatf("v%0d_busy", i),    8'(busy_m), 8'(vecs[i].bz));
      check($sformatf("v%0d_busy_lsb", i), 8'(busy_l), 8'(vecs[i].bz));
      check($sformatf("v%0d_ferr", i),    8'(ferr_m), 8'(vecs[i].fe));
      check($sformatf("v%0d_ferr_lsb", i), 8'(ferr_l), 8'(vecs[i].fe));
      drive(vecs[i].st, vecs[i].va, vecs[i].s);
    end

    // Reset mid-frame: two bits in, then rst pulsed between clock edges.
    @(negedge clk) drive(1, 0, 0);
    @(negedge clk) drive(0, 1, 1);
    @(negedge clk) drive(0, 1, 1);
    @(negedge clk) drive(0, 0, 0);
    check("midrst_busy_before", 8'(busy_m), 8'h1);
    #2 rst = 1'b1;
    #1;
    check("midrst_word", 8'(word_m), 8'h0);
    check("midrst_word_lsb", 8'(word_l), 8'h0);
    check("midrst_load", 8'(load_m), 8'h0);
    check("midrst_busy", 8'(busy_m), 8'h0);
    check("midrst_ferr", 8'(ferr_m), 8'h0);
    #1 rst = 1'b0;
    saw_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (load_m || busy_m || ferr_m) saw_load = 1'b1;
      drive(0, 1, 1);
    end
    check("midrst_no_activity", 8'(saw_load), 8'h0);

    @(negedge clk) drive(1, 0, 0);
    for (int i = 0; i < N; i++) @(negedge clk) drive(0, 1, 1);
    @(negedge clk) drive(0, 0, 0);
    check("post_rst_load", 8'(load_m), 8'h1);
    check("post_rst_word", 8'(word_m), 8'hF);
    check("post_rst_word_lsb", 8'(word_l), 8'hF);
    @(negedge clk);
    check("post_rst_load_off", 8'(load_m), 8'h0);
    check("post_rst_q", 8'(q_reg), 8'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
